// File: rtl/ram_arb_pkg.sv
// Shared types and sizes for the work-RAM arbiter.
// Optional lock/hold feature is enabled by RAM_ARB_LOCK_EN.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_P0,
    OWN_P1,
    OWN_NONE
  } owner_t;

  localparam int RAM_ADDR_W = 12;
  localparam int RAM_DATA_W = 8;

endpackage

// File: rtl/ram_arbiter_if.sv
// Per-requester RAM access port: request bus in, grant/read data out.
// The lock signal exists only when RAM_ARB_LOCK_EN is defined.
interface ram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
`ifdef RAM_ARB_LOCK_EN
  logic              lock;
`endif
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

`ifdef RAM_ARB_LOCK_EN
  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );
  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );
`else
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
`endif

endinterface

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker; lock lets the last winner keep the RAM.
// Lock is pre-qualified by the caller (owner request and hold budget).
module ram_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    winner = 1'b0;
    valid  = |req;
    unique case (1'b1)
      (req == 2'b11): winner = lock ? last : ~last;
      (req == 2'b10): winner = 1'b1;
      (req == 2'b01): winner = 1'b0;
      default:        winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sharing of a single-port sync RAM between two ports.
// Define RAM_ARB_LOCK_EN to add per-port lock with MAX_HOLD fairness.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int MAX_HOLD = 16
) (
  input  logic              hwclk,
  input  logic              reset,
  ram_arbiter_if.slave      p0,
  ram_arbiter_if.slave      p1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  logic              rr_last;
  logic [1:0]        req;
  logic              win;
  logic              win_valid;
  logic              lock_eff;
  logic              we_sel;
  owner_t            rd_owner;
  owner_t            rd_owner_d;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // Gating req keeps grants and ram_we low for the whole reset.
  assign req = {p1.req, p0.req} & {2{~reset}};

`ifdef RAM_ARB_LOCK_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic              owner_lock;
  logic [HOLD_W-1:0] hold_cnt;

  assign owner_lock = rr_last ? (p1.req & p1.lock)
                              : (p0.req & p0.lock);
  assign lock_eff   = owner_lock &&
                      (hold_cnt < HOLD_W'(MAX_HOLD));

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (!owner_lock) begin
      hold_cnt <= '0;
    end else if (win_valid && (&req)) begin
      hold_cnt <= lock_eff ? hold_cnt + 1'b1 : '0;
    end
  end
`else
  assign lock_eff = 1'b0;
`endif

  ram_arb_rr u_rr (
    .req    (req),
    .last   (rr_last),
    .lock   (lock_eff),
    .winner (win),
    .valid  (win_valid)
  );

  always_comb begin
    p0.gnt   = win_valid & ~win;
    p1.gnt   = win_valid & win;
    we_sel   = p0.we;
    ram_addr = p0.addr;
    ram_din  = p0.wdata;
    if (win_valid && win) begin
      we_sel   = p1.we;
      ram_addr = p1.addr;
      ram_din  = p1.wdata;
    end
    ram_we = win_valid & we_sel;
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (win_valid && !we_sel) begin
      rd_owner_d = win ? OWN_P1 : OWN_P0;
    end
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      rr_last  <= 1'b1;
      rd_owner <= OWN_NONE;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (win_valid) rr_last <= win;
      rd_owner <= rd_owner_d;
      if (p0.rvalid) rdata0_q <= ram_dout;
      if (p1.rvalid) rdata1_q <= ram_dout;
    end
  end

  // RAM output is already registered; route it straight to the owner.
  assign p0.rvalid = (rd_owner == OWN_P0);
  assign p1.rvalid = (rd_owner == OWN_P1);
  assign p0.rdata  = p0.rvalid ? ram_dout : rdata0_q;
  assign p1.rdata  = p1.rvalid ? ram_dout : rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural sync RAM.
// Lock sequence runs only when RAM_ARB_LOCK_EN is defined.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
`ifdef RAM_ARB_LOCK_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic          hwclk = 1'b0;
  logic          reset;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_we;

  logic [7:0] mem   [4096];
  logic [7:0] model [4096];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int checks   = 0;
  int failures = 0;

  always #5 hwclk = ~hwclk;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

  ram_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_HOLD (MH)
  ) dut (
    .hwclk    (hwclk),
    .reset    (reset),
    .p0       (p0_if),
    .p1       (p1_if),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  always @(posedge hwclk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  always @(negedge hwclk) begin
    if (p0_if.rvalid === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL p0_rvalid: got 1 want 0");
      end else begin
        chk("p0_rdata", p0_if.rdata, q0.pop_front());
      end
    end
    if (p1_if.rvalid === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL p1_rvalid: got 1 want 0");
      end else begin
        chk("p1_rdata", p1_if.rdata, q1.pop_front());
      end
    end
  end

  task automatic drive(input logic r0, input logic w0,
                       input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0,
                       input logic r1, input logic w1,
                       input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1);
    p0_if.req = r0; p0_if.we = w0;
    p0_if.addr = a0; p0_if.wdata = d0;
    p1_if.req = r1; p1_if.we = w1;
    p1_if.addr = a1; p1_if.wdata = d1;
  endtask

  task automatic step(input logic r0, input logic w0,
                      input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0,
                      input logic r1, input logic w1,
                      input logic [AW-1:0] a1,
                      input logic [DW-1:0] d1,
                      input logic e0, input logic e1,
                      input bit push = 1'b1);
    @(negedge hwclk);
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    #1;
    chk("p0_gnt", p0_if.gnt, e0);
    chk("p1_gnt", p1_if.gnt, e1);
    chk("ram_we", ram_we, (e0 & w0) | (e1 & w1));
    chk("ram_addr", ram_addr, e1 ? a1 : a0);
    if (e0 | e1) chk("ram_din", ram_din, e1 ? d1 : d0);
    if (e0) begin
      if (w0) model[a0] = d0;
      else if (push) q0.push_back(model[a0]);
    end
    if (e1) begin
      if (w1) model[a1] = d1;
      else if (push) q1.push_back(model[a1]);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(negedge hwclk);
    reset = 1'b1;
    @(negedge hwclk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]   = i[7:0] ^ 8'h5A;
      model[i] = i[7:0] ^ 8'h5A;
    end
    mem[5]   = 8'hA5;
    model[5] = 8'hA5;
`ifdef RAM_ARB_LOCK_EN
    p0_if.lock = 1'b0;
    p1_if.lock = 1'b0;
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge hwclk);
    @(negedge hwclk);
    chk("rst_p0_gnt", p0_if.gnt, 0);
    chk("rst_p1_gnt", p1_if.gnt, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_p0_rvalid", p0_if.rvalid, 0);
    chk("rst_p1_rvalid", p1_if.rvalid, 0);
    chk("rst_p0_rdata", p0_if.rdata, 0);
    chk("rst_p1_rdata", p1_if.rdata, 0);
    reset = 1'b0;

    // single read of preloaded word
    step(1, 0, 12'h005, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    chk("p0_rdata_hold", p0_if.rdata, 8'hA5);
    chk("p0_rvalid_low", p0_if.rvalid, 0);

    // write at top address, then read it back
    step(0, 0, 0, 0, 1, 1, 12'hFFF, 8'h3C, 0, 1);
    step(1, 0, 12'hFFF, 0, 0, 0, 0, 0, 1, 0);
    chk("p1_no_rvalid_wr", p1_if.rvalid, 0);
    idle(1);
    chk("p1_no_rvalid_rd", p1_if.rvalid, 0);
    idle(1);

    // continuous contention alternates from reset
    pulse_reset();
    for (int k = 0; k < 6; k++)
      step(1, 0, 12'h010, 0, 1, 0, 12'h020, 0,
           (k % 2) == 0, (k % 2) == 1);
    idle(2);

    // reset lands before a granted read returns
    step(0, 0, 0, 0, 1, 0, 12'h030, 0, 0, 1, 1'b0);
    #1 reset = 1'b1;
    drive(1, 1, 12'h040, 8'h11, 1, 0, 12'h030, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge hwclk);
      #1;
      chk("rst_gnt0", p0_if.gnt, 0);
      chk("rst_gnt1", p1_if.gnt, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_rvalid1", p1_if.rvalid, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // idle stretch must not move rr_last
    step(0, 0, 0, 0, 1, 0, 12'h020, 0, 0, 1);
    idle(10);
    step(1, 0, 12'h007, 0, 1, 0, 12'h008, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 12'h008, 0, 0, 1);
    idle(2);

`ifdef RAM_ARB_LOCK_EN
    pulse_reset();
    p0_if.lock = 1'b1;
    step(1, 0, 12'h050, 0, 1, 0, 12'h060, 0, 1, 0);
    for (int k = 0; k < 4; k++)
      step(1, 0, 12'h050, 0, 1, 0, 12'h060, 0, 1, 0);
    step(1, 0, 12'h050, 0, 1, 0, 12'h060, 0, 0, 1);
    step(1, 0, 12'h050, 0, 1, 0, 12'h060, 0, 1, 0);
    p0_if.lock = 1'b0;
    idle(2);
`endif

    idle(2);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
